// File: rtl/hub75_panel_rx.sv
// hub75_panel_rx: panel-side HUB75 receiver (emulated LED panel).
// Samples the HUB75 pins with clk, rebuilds the column shift register,
// captures a row on each latch and streams it out as valid/ready beats,
// and measures the length of every OE-active (display) interval.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   h75_clk/lat/oe    HUB75 shift clock, latch, output enable (active low)
//   h75_addr, h75_rgb row address {E,D,C,B,A}, colour {B2,G2,R2,B1,G1,R1}
//   out_*             pixel stream (valid/ready), out_last on column COLS-1
//   shift_cnt         shifts seen in the latched row (saturates at COLS)
//   oe_cycles/valid   last OE-low interval length, one-cycle update pulse
//   overrun           sticky: latch arrived while the stream was busy
module hub75_panel_rx #(
  parameter int unsigned COLS        = 64,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OE_CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     h75_clk,
  input  logic                     h75_lat,
  input  logic                     h75_oe,
  input  logic [4:0]               h75_addr,
  input  logic [5:0]               h75_rgb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_row,
  output logic [$clog2(COLS)-1:0]  out_col,
  output logic [5:0]               out_rgb,
  output logic                     out_last,
  output logic [$clog2(COLS):0]    shift_cnt,
  output logic [OE_CNT_BITS-1:0]   oe_cycles,
  output logic                     oe_valid,
  output logic                     overrun
);

  localparam int unsigned CW  = $clog2(COLS);
  localparam int unsigned SCW = CW + 1;

  typedef struct packed {
    logic       clk;
    logic       lat;
    logic       oe;
    logic [4:0] addr;
    logic [5:0] rgb;
  } pins_t;

  // Idle pin levels: clocks low, OE inactive (high).
  localparam pins_t PINS_IDLE = pins_t'({1'b0, 1'b0, 1'b1, 5'd0, 6'd0});

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  pins_t           sync_q [SYNC_STAGES];
  pins_t           pins;
  logic            clk_d, lat_d, oe_d;
  logic            shift_edge, lat_edge, oe_fall, oe_rise;

  logic [5:0]      sreg_q [COLS];
  logic [5:0]      sreg_n [COLS];
  logic [5:0]      lbuf_q [COLS];
  logic [SCW-1:0]  pend_q, pend_sh;

  state_t          state_q, state_d;
  logic            load;
  logic [CW-1:0]   col_d, col_nx;
  logic [5:0]      rgb_d;
  logic            last_d, valid_d, overrun_d;
  logic [4:0]      row_d;
  logic [SCW-1:0]  scnt_d;

  logic [OE_CNT_BITS-1:0] oe_cnt;

  // Synchronizers: every pin goes through the same depth so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PINS_IDLE;
      clk_d <= 1'b0;
      lat_d <= 1'b0;
      oe_d  <= 1'b1;
    end else begin
      sync_q[0] <= pins_t'({h75_clk, h75_lat, h75_oe, h75_addr, h75_rgb});
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      clk_d <= pins.clk;
      lat_d <= pins.lat;
      oe_d  <= pins.oe;
    end
  end

  assign pins       = sync_q[SYNC_STAGES-1];
  assign shift_edge = pins.clk & ~clk_d;
  assign lat_edge   = pins.lat & ~lat_d;
  assign oe_fall    = ~pins.oe & oe_d;
  assign oe_rise    = pins.oe & ~oe_d;

  // Shift register after this cycle's shift; a same-cycle latch sees it.
  always_comb begin
    sreg_n = sreg_q;
    if (shift_edge) begin
      sreg_n[0] = pins.rgb;
      for (int unsigned k = 1; k < COLS; k++) sreg_n[k] = sreg_q[k-1];
    end
  end

  assign pend_sh = (shift_edge && pend_q != SCW'(COLS)) ? pend_q + SCW'(1) : pend_q;

  // Shift register and line buffer storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '{default: '0};
      lbuf_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      sreg_q <= sreg_n;
      if (load) lbuf_q <= sreg_n;
      pend_q <= lat_edge ? '0 : pend_sh;
    end
  end

  assign col_nx = out_col + CW'(1);

  // Stream FSM: next state and registered-output next values.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    col_d     = out_col;
    rgb_d     = out_rgb;
    last_d    = out_last;
    valid_d   = out_valid;
    row_d     = out_row;
    scnt_d    = shift_cnt;
    overrun_d = overrun;
    case (state_q)
      S_IDLE: begin
        if (lat_edge) begin
          state_d = S_STREAM;
          load    = 1'b1;
          row_d   = pins.addr;
          scnt_d  = pend_sh;
          col_d   = '0;
          rgb_d   = sreg_n[0];
          last_d  = (COLS == 1);
          valid_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (lat_edge) overrun_d = 1'b1;
        if (out_valid && out_ready) begin
          if (out_last) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            col_d  = col_nx;
            rgb_d  = lbuf_q[col_nx];
            last_d = (col_nx == CW'(COLS - 1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_rgb   <= '0;
      out_last  <= 1'b0;
      shift_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_row   <= row_d;
      out_col   <= col_d;
      out_rgb   <= rgb_d;
      out_last  <= last_d;
      shift_cnt <= scnt_d;
      overrun   <= overrun_d;
    end
  end

  // OE-low interval counter; the falling-edge cycle itself counts as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_cnt    <= '0;
      oe_cycles <= '0;
      oe_valid  <= 1'b0;
    end else begin
      oe_valid <= 1'b0;
      if (oe_fall) begin
        oe_cnt <= OE_CNT_BITS'(1);
      end else if (!pins.oe && !oe_d && oe_cnt != '1) begin
        oe_cnt <= oe_cnt + OE_CNT_BITS'(1);
      end
      if (oe_rise) begin
        oe_cycles <= oe_cnt;
        oe_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hub75_panel_rx.sv
// tb_hub75_panel_rx: directed bench for hub75_panel_rx. A reference shift
// register model fills a scoreboard queue of expected beats at each latch;
// the stream monitor compares every valid cycle against the queue head.
module tb_hub75_panel_rx;

  localparam int COLS = 64;

  typedef struct packed {
    logic [4:0] row;
    logic [5:0] col;
    logic [5:0] rgb;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h75_clk = 1'b0;
  logic        h75_lat = 1'b0;
  logic        h75_oe = 1'b1;
  logic [4:0]  h75_addr = '0;
  logic [5:0]  h75_rgb = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [4:0]  out_row;
  logic [5:0]  out_col;
  logic [5:0]  out_rgb;
  logic        out_last;
  logic [6:0]  shift_cnt;
  logic [15:0] oe_cycles;
  logic        oe_valid;
  logic        overrun;

  beat_t       exp_q[$];
  logic [5:0]  model [COLS];
  int          total = 0;
  int          bad = 0;
  int          beats = 0;
  int          oe_pulses = 0;
  int          oe_exp = 0;

  hub75_panel_rx #(.COLS(64), .SYNC_STAGES(2), .OE_CNT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .h75_clk(h75_clk), .h75_lat(h75_lat), .h75_oe(h75_oe),
    .h75_addr(h75_addr), .h75_rgb(h75_rgb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_rgb(out_rgb), .out_last(out_last),
    .shift_cnt(shift_cnt), .oe_cycles(oe_cycles), .oe_valid(oe_valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Stream monitor: every valid cycle must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_beat obs col=%0d rgb=%h exp=none", out_col, out_rgb);
      end
      if (exp_q.size() > 0) begin
        beat_t got, e;
        got = {out_row, out_col, out_rgb, out_last};
        e = exp_q[0];
        total++;
        assert (got === e) else begin
          bad++;
          $error("FAIL beat obs=%h exp=%h (row,col,rgb,last)", got, e);
        end
        if (out_ready) begin
          e = exp_q.pop_front();
          beats++;
        end
      end
    end
  end

  // OE monitor.
  always @(negedge clk) begin
    if (rst_n && oe_valid) begin
      oe_pulses++;
      total++;
      assert (32'(oe_cycles) === oe_exp) else begin
        bad++;
        $error("FAIL oe_cycles obs=%0d exp=%0d", oe_cycles, oe_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic shift_word(input logic [5:0] w);
    h75_rgb = w;
    tick(2);
    h75_clk = 1'b1;
    tick(2);
    h75_clk = 1'b0;
    for (int k = COLS - 1; k > 0; k--) model[k] = model[k-1];
    model[0] = w;
  endtask

  task automatic latch(input logic [4:0] a, input bit accept);
    beat_t e;
    if (accept) begin
      beats = 0;
      for (int k = 0; k < COLS; k++) begin
        e.row  = a;
        e.col  = 6'(k);
        e.rgb  = model[k];
        e.last = (k == COLS - 1);
        exp_q.push_back(e);
      end
    end
    h75_addr = a;
    tick(2);
    h75_lat = 1'b1;
    tick(2);
    h75_lat = 1'b0;
    tick(2);
  endtask

  // Wait for the stream to finish; bp selects the 1,0,0,1 ready pattern.
  task automatic drain(input bit bp);
    for (int c = 0; c < 2000; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      if (bp) out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick(1);
    end
    out_ready = 1'b1;
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    for (int k = 0; k < COLS; k++) model[k] = '0;

    // Reset with pins toggling.
    for (int i = 0; i < 10; i++) begin
      h75_clk = ~h75_clk; h75_lat = ~h75_lat; h75_oe = ~h75_oe;
      h75_addr = 5'(i); h75_rgb = 6'(i * 5);
      tick(1);
    end
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_row", 32'(out_row), 0);
    chk("rst_col", 32'(out_col), 0);
    chk("rst_rgb", 32'(out_rgb), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_shift_cnt", 32'(shift_cnt), 0);
    chk("rst_oe_cycles", 32'(oe_cycles), 0);
    chk("rst_oe_valid", 32'(oe_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    h75_clk = 1'b0; h75_lat = 1'b0; h75_oe = 1'b1; h75_addr = '0; h75_rgb = '0;
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("idle_valid", 32'(out_valid), 0);

    // Full row, sink always ready: column k carries rgb k.
    out_ready = 1'b1;
    for (int i = 0; i < COLS; i++) shift_word(6'(63 - i));
    latch(5'd5, 1'b1);
    drain(1'b0);
    chk("full_beats", 32'(beats), 64);
    chk("full_shift_cnt", 32'(shift_cnt), 64);
    tick(2);
    chk("full_idle", 32'(out_valid), 0);
    chk("full_overrun", 32'(overrun), 0);

    // Backpressure with ready pattern 1,0,0,1.
    for (int i = 0; i < COLS; i++) shift_word(6'((i * 7 + 3) & 63));
    latch(5'd17, 1'b1);
    drain(1'b1);
    chk("bp_beats", 32'(beats), 64);
    chk("bp_shift_cnt", 32'(shift_cnt), 64);

    // Short row, then an overrunning latch while stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) shift_word(6'(i + 40));
    latch(5'd9, 1'b1);
    tick(1);
    chk("short_shift_cnt", 32'(shift_cnt), 10);
    chk("short_overrun_pre", 32'(overrun), 0);
    for (int i = 0; i < 3; i++) shift_word(6'(i + 1));
    latch(5'd2, 1'b0);
    tick(1);
    chk("overrun_set", 32'(overrun), 1);
    chk("overrun_row", 32'(out_row), 9);
    chk("overrun_shift_cnt", 32'(shift_cnt), 10);
    out_ready = 1'b1;
    drain(1'b0);
    chk("short_beats", 32'(beats), 64);
    chk("overrun_sticky", 32'(overrun), 1);

    // OE interval measurement.
    oe_exp = 50;
    h75_oe = 1'b0;
    tick(50);
    h75_oe = 1'b1;
    tick(10);
    chk("oe_pulses_50", 32'(oe_pulses), 1);
    oe_exp = 65535;
    h75_oe = 1'b0;
    tick(70000);
    h75_oe = 1'b1;
    tick(10);
    chk("oe_pulses_sat", 32'(oe_pulses), 2);

    // Reset in the middle of a stream.
    for (int i = 0; i < COLS; i++) shift_word(6'(i ^ 21));
    latch(5'd30, 1'b1);
    for (int c = 0; c < 400 && beats < 20; c++) tick(1);
    chk("beat20_reached", 32'(beats >= 20), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_overrun", 32'(overrun), 0);
    chk("post_rst_shift_cnt", 32'(shift_cnt), 0);
    for (int k = 0; k < COLS; k++) model[k] = '0;
    for (int i = 0; i < COLS; i++) shift_word(6'((i * 3) & 63));
    latch(5'd3, 1'b1);
    drain(1'b0);
    chk("post_rst_beats", 32'(beats), 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_panel_rx.md
Name: hub75_panel_rx

Overview:
- Panel-side receiver for the HUB75 interface: it is the other end of the matrix drivers, in the role of an emulated LED panel.
- Samples the HUB75 pins (Clk, Lat, OE, A–E, R1/G1/B1/R2/G2/B2) with the system clock and rebuilds the column shift register.
- On each latch it captures the row and streams it out as a valid/ready pixel stream, and it measures each OE-active (display) interval.
- Used as an on-chip loopback checker and as a bench monitor for driver blocks.

Parameters:
- COLS, 64: panel width in columns; depth of the shift register and of the line buffer.
- SYNC_STAGES, 2: synchronizer flops applied to every HUB75 input. The same stage count is used on all inputs so they stay mutually aligned.
- OE_CNT_BITS, 16: width of the OE-active cycle counter.

Ports:
- clk  in  1  system clock (27 MHz).
- rst_n  in  1  reset.
- h75_clk  in  1  HUB75 shift clock; data is taken on its rising edge.
- h75_lat  in  1  HUB75 latch; the row is captured on its rising edge.
- h75_oe  in  1  HUB75 output enable, active low.
- h75_addr  in  5  row address {E,D,C,B,A}.
- h75_rgb  in  6  {B2,G2,R2,B1,G1,R1}.
- out_valid  out  1  stream pixel valid.
- out_ready  in  1  stream sink ready.
- out_row  out  5  latched row address.
- out_col  out  $clog2(COLS)  column index, 0 = first column on the panel.
- out_rgb  out  6  pixel colour bits for column out_col.
- out_last  out  1  high with the column COLS-1 beat.
- shift_cnt  out  $clog2(COLS)+1  shifts seen in the latched row, saturating at COLS.
- oe_cycles  out  OE_CNT_BITS  length of the last OE-low interval, in clk cycles.
- oe_valid  out  1  one-cycle pulse when oe_cycles updates.
- overrun  out  1  sticky: a latch arrived while the stream was busy.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Every flop clears while rst_n = 0, including synchronizers, shift register, line buffer, FSM and counters.
  - Outputs while in reset: out_valid=0, out_row=0, out_col=0, out_rgb=0, out_last=0, shift_cnt=0, oe_cycles=0, oe_valid=0, overrun=0.
  - Synchronizer flops reset to the idle pin levels: h75_clk=0, h75_lat=0, h75_oe=1 (OE inactive).
  - Reset mid-stream abandons the row; no partial beats follow after release.
- Sampling:
  - All pins pass through SYNC_STAGES flops.
  - Edges are detected on the last stage against one extra delayed copy.
  - Edge-to-action latency from the pin: SYNC_STAGES+1 clk cycles.
  - Each h75_clk/h75_lat high and low phase must last at least 2 clk cycles; shorter pulses are not required to be seen.
- Shift:
  - On a synchronized h75_clk rising edge, the register shifts toward higher column index and h75_rgb enters column 0.
  - After COLS shifts, the first word shifted in sits at column COLS-1, matching real panel order.
  - A pending shift counter increments per edge, saturating at COLS.
- Latch, on a synchronized h75_lat rising edge:
  - FSM in IDLE: copy the shift register into the line buffer, capture h75_addr into out_row, and copy the pending count into shift_cnt. Clear the pending count, go to STREAM with column index 0.
  - FSM in STREAM: the line buffer, out_row and shift_cnt are unchanged, overrun is set, and the pending count is still cleared.
  - The shift register itself is never cleared by a latch. A row with fewer than COLS shifts streams the stale upper columns; shift_cnt < COLS flags this.
  - A shift edge and a latch edge in the same cycle: the shift is applied first and the latched data includes it.
- Stream FSM:
  - IDLE → STREAM on an accepted latch.
  - In STREAM, out_valid=1 and out_col/out_rgb/out_last reflect the current column.
  - A beat transfers when out_valid && out_ready; the column then increments.
  - The transfer at column COLS-1 (out_last=1) returns the FSM to IDLE with out_valid=0 the next cycle.
  - out_col, out_rgb and out_row are held stable while out_valid=1 and out_ready=0.
  - The first beat is valid one cycle after the latch edge is detected.
  - Shifting continues normally during STREAM.
- OE measurement:
  - A synchronized h75_oe falling edge clears the counter to 1.
  - Each following cycle with OE low increments it, saturating at 2^OE_CNT_BITS-1.
  - On the rising edge, oe_cycles takes the count and oe_valid pulses for one cycle.
  - This path is independent of the stream FSM.
- overrun clears only on reset.

Test Plan:
- Reset behaviour: hold rst_n=0 with pins toggling → all outputs 0; release with no edges → out_valid stays 0.
- Full row: shift 64 words rgb=col[5:0] (first word 0x3F down to 0x00), addr=5, pulse lat, out_ready=1 → 64 beats, out_row=5, beat col k has rgb=k, out_last only at col 63, shift_cnt=64.
- Backpressure: out_ready toggled 1,0,0,1… during the full-row scenario → no beat lost or duplicated, data held while stalled; total 64 beats.
- Short row and overrun: latch after 10 shifts → shift_cnt=10; second lat pulse during streaming with out_ready=0 → overrun=1, stream contents and out_row unchanged.
- OE timing: drive h75_oe low for 50 clk cycles then high → one oe_valid pulse with oe_cycles=50; low for 70000 cycles → oe_cycles=65535.
- Reset mid-stream: assert rst_n=0 at beat 20 → out_valid=0 immediately; after release, a new latch streams from col 0.
